// File: rtl/dac_sample_scheduler_pkg.sv
// dac_sched_pkg: shared sizes and types for the DAC sample scheduler
package dac_sched_pkg;
    localparam int DATA_W     = 10;
    localparam int FIFO_DEPTH = 4;
    localparam int DIV_W      = 8;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
    typedef logic [DATA_W-1:0] sample_t;
    typedef enum logic {RR_CPU, RR_RAMP} rr_e;
endpackage

// File: rtl/dac_sample_scheduler_if.sv
// dac_sample_scheduler_if: sample sources, rate control and DAC output bus
interface dac_sample_scheduler_if;
    import dac_sched_pkg::*;
    logic             cpu_valid;
    sample_t          cpu_data;
    logic             cpu_ready;
    logic             ramp_en;
    sample_t          ramp_step;
    logic [DIV_W-1:0] div_cfg;
    logic             clr_flags;
    logic             dac_en;
    sample_t          dac_d;
    logic [LVL_W-1:0] fifo_level;
    logic             underflow;
    modport master (
        output cpu_valid, cpu_data, ramp_en, ramp_step, div_cfg, clr_flags,
        input  cpu_ready, dac_en, dac_d, fifo_level, underflow
    );
    modport slave (
        input  cpu_valid, cpu_data, ramp_en, ramp_step, div_cfg, clr_flags,
        output cpu_ready, dac_en, dac_d, fifo_level, underflow
    );
endinterface

// File: rtl/dac_sample_scheduler_fifo.sv
// sync_fifo: sample storage with registered occupancy; ignores push when full, pop when empty
module sync_fifo
    import dac_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  sample_t          din_i,
    input  logic             pop_i,
    output sample_t          dout_o,
    output logic [LVL_W-1:0] level_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    sample_t          mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;
    assign full_o  = level_q == LVL_W'(FIFO_DEPTH);
    assign empty_o = level_q == '0;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    assign dout_o  = mem_q[rd_q];
    assign level_o = level_q;
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_q + PTR_W'(do_push);
            rd_q    <= rd_q + PTR_W'(do_pop);
            level_q <= level_d;
        end
    end
endmodule

// File: rtl/dac_sample_scheduler.sv
// dac_sample_scheduler: arbitrates core and ramp samples into a FIFO, paces them onto the DAC
module dac_sample_scheduler
    import dac_sched_pkg::*;
(
    input  logic                  CLK,
    input  logic                  reset,
    dac_sample_scheduler_if.slave bus
);
    rr_e              rr_q, rr_d;
    sample_t          ramp_q, ramp_d, dac_d_q, head, din;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             dac_en_q, underflow_q, underflow_d;
    logic             full, empty, tick, pop, push, grant_cpu, grant_ramp, contested;
    assign contested  = bus.cpu_valid & bus.ramp_en;
    assign grant_cpu  = bus.cpu_valid & (~bus.ramp_en | rr_q == RR_CPU);
    assign grant_ramp = bus.ramp_en & (~bus.cpu_valid | rr_q == RR_RAMP);
    assign push       = ~full & (grant_cpu | grant_ramp);
    assign din        = grant_cpu ? bus.cpu_data : ramp_q;
    assign tick       = cnt_q == '0;
    // a tick only sees samples already stored: no same-cycle bypass
    assign pop        = tick & ~empty;
    always_comb begin
        rr_d        = (contested & ~full) ? (rr_q == RR_CPU ? RR_RAMP : RR_CPU) : rr_q;
        ramp_d      = (grant_ramp & ~full) ? ramp_q + bus.ramp_step : ramp_q;
        cnt_d       = tick ? bus.div_cfg : cnt_q - 1'b1;
        underflow_d = (tick & empty & dac_en_q) | (underflow_q & ~bus.clr_flags);
    end
    always_ff @(posedge CLK) begin
        if (reset) begin
            rr_q        <= RR_CPU;
            ramp_q      <= '0;
            cnt_q       <= '0;
            dac_d_q     <= '0;
            dac_en_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            ramp_q      <= ramp_d;
            cnt_q       <= cnt_d;
            underflow_q <= underflow_d;
            if (pop) begin
                dac_d_q  <= head;
                dac_en_q <= 1'b1;
            end
        end
    end
    sync_fifo u_fifo (
        .clk     (CLK),
        .rst     (reset),
        .push_i  (push),
        .din_i   (din),
        .pop_i   (pop),
        .dout_o  (head),
        .level_o (bus.fifo_level),
        .full_o  (full),
        .empty_o (empty)
    );
    assign bus.cpu_ready = bus.cpu_valid & ~full & grant_cpu;
    assign bus.dac_en    = dac_en_q;
    assign bus.dac_d     = dac_d_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_dac_sample_scheduler.sv
// tb_dac_sample_scheduler: directed vector table plus hand sequences for contention, full, ramp wrap
module tb_dac_sample_scheduler;
    import dac_sched_pkg::*;
    logic CLK = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    dac_sample_scheduler_if bus ();
    dac_sample_scheduler dut (.CLK(CLK), .reset(reset), .bus(bus));
    always #5 CLK = ~CLK;
    typedef struct {
        logic    rst, cv;
        sample_t cd;
        logic    re;
        sample_t rs;
        logic [7:0] dv;
        logic    clr, rdy, en;
        sample_t d;
        logic [2:0] lvl;
        logic    uf;
    } vec_t;
    vec_t vecs[$];
    task automatic add(input logic rst, cv, input int cd, input logic re, input int rs, dv,
                       input logic clr, rdy, en, input int d, lvl, input logic uf);
        vec_t v;
        v.rst = rst; v.cv = cv; v.cd = sample_t'(cd); v.re = re; v.rs = sample_t'(rs);
        v.dv = 8'(dv); v.clr = clr; v.rdy = rdy; v.en = en; v.d = sample_t'(d);
        v.lvl = 3'(lvl); v.uf = uf;
        vecs.push_back(v);
    endtask
    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask
    task automatic drive(input logic rst, cv, input int cd, input logic re, input int rs, dv, input logic clr);
        reset = rst; bus.cpu_valid = cv; bus.cpu_data = sample_t'(cd); bus.ramp_en = re;
        bus.ramp_step = sample_t'(rs); bus.div_cfg = 8'(dv); bus.clr_flags = clr;
        #1;
    endtask
    task automatic post(input string tag, input logic en, input int d, lvl, input logic uf);
        @(posedge CLK);
        #1;
        chk({tag, " dac_en"}, int'(bus.dac_en), int'(en));
        chk({tag, " dac_d"}, int'(bus.dac_d), d);
        chk({tag, " fifo_level"}, int'(bus.fifo_level), lvl);
        chk({tag, " underflow"}, int'(bus.underflow), int'(uf));
    endtask
    initial begin
        // reset, then core-only pacing at div_cfg=3
        add(1,0,0,0,0,0,0, 0,0,0,0,0);
        add(1,0,0,0,0,0,0, 0,0,0,0,0);
        add(1,0,0,0,0,0,0, 0,0,0,0,0);
        add(0,1,'h155,0,0,3,0, 1,0,0,1,0);
        add(0,1,'h2AA,0,0,3,0, 1,0,0,2,0);
        add(0,0,0,0,0,3,0, 0,0,0,2,0);
        add(0,0,0,0,0,3,0, 0,0,0,2,0);
        add(0,0,0,0,0,3,0, 0,1,'h155,1,0);
        add(0,0,0,0,0,3,0, 0,1,'h155,1,0);
        add(0,0,0,0,0,3,0, 0,1,'h155,1,0);
        add(0,0,0,0,0,3,0, 0,1,'h155,1,0);
        add(0,0,0,0,0,3,0, 0,1,'h2AA,0,0);
        // fill to 3 then reset mid-stream for 3 cycles
        add(0,1,'h001,0,0,3,0, 1,1,'h2AA,1,0);
        add(0,1,'h002,0,0,3,0, 1,1,'h2AA,2,0);
        add(0,1,'h003,0,0,3,0, 1,1,'h2AA,3,0);
        add(1,0,0,0,0,3,0, 0,0,0,0,0);
        add(1,0,0,0,0,3,0, 0,0,0,0,0);
        add(1,0,0,0,0,3,0, 0,0,0,0,0);
        // underflow at div_cfg=1, clr_flags versus a coincident set
        add(0,1,'h0AB,0,0,1,0, 1,0,0,1,0);
        add(0,0,0,0,0,1,0, 0,0,0,1,0);
        add(0,0,0,0,0,1,0, 0,1,'h0AB,0,0);
        add(0,0,0,0,0,1,0, 0,1,'h0AB,0,0);
        add(0,0,0,0,0,1,0, 0,1,'h0AB,0,1);
        add(0,0,0,0,0,1,1, 0,1,'h0AB,0,0);
        add(0,0,0,0,0,1,1, 0,1,'h0AB,0,1);
        add(0,0,0,0,0,1,1, 0,1,'h0AB,0,0);
        add(0,0,0,0,0,1,0, 0,1,'h0AB,0,1);
        add(1,0,0,0,0,0,0, 0,0,0,0,0);
        add(0,0,0,0,0,0,0, 0,0,0,0,0);
        add(0,0,0,0,0,0,0, 0,0,0,0,0);
        add(0,0,0,0,0,0,0, 0,0,0,0,0);
        // fill to full at div_cfg=255
        add(1,0,0,0,0,0,0, 0,0,0,0,0);
        add(0,1,'h011,0,0,255,0, 1,0,0,1,0);
        add(0,1,'h012,0,0,255,0, 1,0,0,2,0);
        add(0,1,'h013,0,0,255,0, 1,0,0,3,0);
        add(0,1,'h014,0,0,255,0, 1,0,0,4,0);
        add(0,1,'h015,0,0,255,0, 0,0,0,4,0);
        add(0,1,'h015,0,0,255,0, 0,0,0,4,0);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].cv, int'(vecs[i].cd), vecs[i].re, int'(vecs[i].rs),
                  int'(vecs[i].dv), vecs[i].clr);
            chk($sformatf("v%0d cpu_ready", i), int'(bus.cpu_ready), int'(vecs[i].rdy));
            post($sformatf("v%0d", i), vecs[i].en, int'(vecs[i].d), int'(vecs[i].lvl), vecs[i].uf);
        end
        // stays full until the divider reloads, then one pop frees a slot
        for (int i = 0; i < 250; i++) begin
            drive(0,1,'h015,0,0,255,0);
            chk($sformatf("full%0d cpu_ready", i), int'(bus.cpu_ready), 0);
            post($sformatf("full%0d", i), 0, 0, 4, 0);
        end
        drive(0,1,'h015,0,0,255,0);
        chk("full tick cpu_ready", int'(bus.cpu_ready), 0);
        post("full tick", 1, 'h011, 3, 0);
        drive(0,1,'h015,0,0,255,0);
        chk("full refill cpu_ready", int'(bus.cpu_ready), 1);
        post("full refill", 1, 'h011, 4, 0);
        // contention: alternating grants, DAC shows 3FF / ramp 0,1,2...
        drive(1,0,0,0,0,0,0);
        post("cont rst", 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            drive(0,1,'h3FF,1,1,0,0);
            chk($sformatf("cont%0d cpu_ready", i), int'(bus.cpu_ready), i % 2);
            post($sformatf("cont%0d", i), i >= 2, i < 2 ? 0 : (i % 2 == 0 ? 'h3FF : (i - 3) / 2), 1, 0);
        end
        // ramp wrap with step 0x200
        drive(1,0,0,0,0,0,0);
        post("wrap rst", 0, 0, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            drive(0,0,0,1,'h200,0,0);
            post($sformatf("wrap%0d", i), i >= 2, (i < 2 || i % 2 == 0) ? 0 : 'h200, 1, 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
